cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control FSM for the RV32I core. It issues the instruction fetch and data-memory handshakes and consumes `opcode`/`funct3` from the instruction decoder. It generates every register, PC, ALU-mux and write-back strobe that steps one instruction through fetch, decode, execute, memory and write-back. It sits between the instruction/data memory ports and the decoder/ALU/register-file datapath, and also keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 32: width of `retire_cnt`.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `imem_req`  out  1: instruction fetch request.
- `imem_ready`  in  1: fetch data valid this cycle.
- `dmem_req`  out  1: data access request.
- `dmem_we`  out  1: store (1) or load (0); valid while `dmem_req`.
- `dmem_ready`  in  1: data access complete this cycle.
- `opcode`  in  7: from decoder; valid in DECODE onward.
- `funct3`  in  3: from decoder; reserved for branch/load qualification, passed to `cpu_op_class`.
- `br_taken`  in  1: ALU branch-compare result; valid in EXEC.
- `ir_we`  out  1: latch instruction register.
- `pc_we`  out  1: update PC.
- `pc_sel`  out  2: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result (JALR).
- `alu_src_a`  out  1: 0 = rs1, 1 = PC.
- `alu_src_b`  out  1: 0 = rs2, 1 = imm.
- `reg_we`  out  1: register-file write.
- `wb_sel`  out  2: 0 = ALU, 1 = load data, 2 = PC+4.
- `halt`  out  1: core stopped.
- `trap`  out  1: illegal-opcode stop (macro-dependent).
- `retire_cnt`  out  CNT_W: instructions retired.

## Operation
States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT.

Transitions:
- RESET → FETCH unconditionally.
- FETCH: `imem_req`=1. It holds until `imem_ready`. In the cycle `imem_ready`=1, `ir_we`=1 (Mealy) and the next state is DECODE.
- DECODE: one cycle; the opcode class is registered here. SYSTEM (1110011) → HALT. Every other class → EXEC.
- EXEC, by class:
  - R (0110011) and I-ALU (0010011) → WB.
  - LUI (0110111) and AUIPC (0010111) → WB.
  - JAL (1101111) and JALR (1100111) → WB.
  - Load (0000011) and store (0100011) → MEM.
  - Branch (1100011): asserts `pc_we`, with `pc_sel` = `br_taken` ? 1 : 0, then → FETCH.
- MEM: `dmem_req`=1 and `dmem_we`=store, held until `dmem_ready`.
  - Load + ready → WB.
  - Store + ready: `pc_we`, `pc_sel`=0, then → FETCH.
- WB: `reg_we`=1 and `pc_we`=1, then → FETCH.
  - `wb_sel`: 1 for load, 2 for JAL/JALR, 0 otherwise.
  - `pc_sel`: 1 for JAL, 2 for JALR, 0 otherwise.
- HALT: absorbing until `rst`. `halt`=1.

ALU mux settings, asserted in EXEC and held through MEM/WB:
- `alu_src_a`=1 for AUIPC, JAL and branch.
- `alu_src_b`=1 for everything except R-type and branch.

Counter and idle outputs:
- `retire_cnt` increments by 1 in every cycle with `pc_we`=1. It wraps modulo 2^CNT_W with no saturation.
- All strobes not listed for a state are 0.

## Timing
- Reset: asynchronous.
  - State goes to RESET and `retire_cnt` clears to 0.
  - All outputs go to 0 immediately, including any in-flight `imem_req`/`dmem_req`.
  - The first FETCH occurs in the second cycle after `rst` deasserts.
- Latency with zero-wait memory (ready high in the first request cycle):
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR and store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle on `imem_ready`/`dmem_ready` adds exactly one cycle.
- Handshake:
  - A request stays high and stable until the cycle ready is sampled high. It drops in the following cycle.
  - Ready is ignored while the matching request is low.
- The `opcode` input is sampled only in DECODE. Changes elsewhere have no effect.

## Configuration
- `CPU_SEQ_ILLEGAL_TRAP_EN` defined:
  - An opcode outside the ten listed classes in DECODE → HALT with `trap`=1 and `halt`=1.
  - The instruction does not retire.
- Not defined:
  - An unknown opcode is a NOP: DECODE → EXEC, then `pc_we` with `pc_sel`=0 → FETCH.
  - No `reg_we` is issued and the NOP retires.
  - `trap` is tied to 0.

## Structure
- Package `cpu_pkg` holds:
  - Opcode localparams.
  - The state encoding.
  - The op-class encoding.
  - `pc_sel`/`wb_sel` encodings (shared with the datapath muxes).
- Sub-module `cpu_op_class`: combinational opcode → class and illegal flag.
- The FSM, output decode and retire counter live in `cpu_sequencer`.

## Test plan
- ADDI (0010011), `imem_ready` and `dmem_ready` tied high → `ir_we` in cycle 1 after FETCH entry and `reg_we`+`pc_we` in cycle 4, with `wb_sel`=0, `pc_sel`=0 and `alu_src_b`=1; `retire_cnt` goes 0→1.
- LW with `dmem_ready` delayed 3 cycles → `dmem_req`=1 and `dmem_we`=0 held for 4 cycles, then WB with `wb_sel`=1; total 8 cycles.
- BEQ with `br_taken`=1, then BEQ with `br_taken`=0 → EXEC `pc_we` with `pc_sel`=1, then 0, and no `reg_we`; 3 cycles each.
- JALR → WB with `pc_sel`=2, `wb_sel`=2 and `reg_we`=1.
- `rst` pulsed mid-MEM with `dmem_req` high → `dmem_req` is 0 in the same cycle, `retire_cnt`=0, and FETCH is entered 2 cycles after release.
- Opcode 0001111, both builds → with the macro, HALT with `trap`=1 and the count unchanged; without it, NOP that retires. ECALL → `halt`=1 permanently and `imem_req` stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: opcodes, FSM states,
// opcode classes and the pc_sel / wb_sel mux codes used by the datapath.
package cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_R, CLS_IALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
    CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_SYSTEM, CLS_NOP
  } op_class_t;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [1:0] PC_SEL_ALU   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU   = 2'd0;
  localparam logic [1:0] WB_SEL_MEM   = 2'd1;
  localparam logic [1:0] WB_SEL_PC4   = 2'd2;

endpackage

// File: rtl/cpu_op_class.sv
// Combinational opcode classifier; anything outside the ten known classes is
// reported as NOP with the illegal flag raised.
module cpu_op_class
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output op_class_t  op_class,
  output logic       illegal
);

  // funct3 is carried for future branch/load qualification
  logic funct3_unused;
  assign funct3_unused = ^funct3;

  always_comb begin
    op_class = CLS_NOP;
    illegal  = 1'b0;
    case (opcode)
      OP_R:      op_class = CLS_R;
      OP_IALU:   op_class = CLS_IALU;
      OP_LUI:    op_class = CLS_LUI;
      OP_AUIPC:  op_class = CLS_AUIPC;
      OP_JAL:    op_class = CLS_JAL;
      OP_JALR:   op_class = CLS_JALR;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_SYSTEM: op_class = CLS_SYSTEM;
      default:   illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control FSM with retired-instruction counter.
// Optional CPU_SEQ_ILLEGAL_TRAP_EN: unknown opcodes halt with trap instead of NOP.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             halt,
  output logic             trap,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t    state, next_state;
  op_class_t cls_q, cls_dec;
  logic      illegal_dec;
  logic      trap_q;

  cpu_op_class u_op_class (
    .opcode   (opcode),
    .funct3   (funct3),
    .op_class (cls_dec),
    .illegal  (illegal_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
      cls_q <= CLS_NOP;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) cls_q <= cls_dec;
    end
  end

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   trap_q <= 1'b0;
    else if (state == ST_DECODE && illegal_dec) trap_q <= 1'b1;
  end
`else
  logic illegal_unused;
  assign illegal_unused = illegal_dec;
  assign trap_q         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        retire_cnt <= '0;
    else if (pc_we) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RESET:  next_state = ST_FETCH;
      ST_FETCH:  if (imem_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        if (cls_dec == CLS_SYSTEM) next_state = ST_HALT;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
        else if (illegal_dec)      next_state = ST_HALT;
`endif
        else                       next_state = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE:  next_state = ST_MEM;
          CLS_BRANCH, CLS_NOP:  next_state = ST_FETCH;
          default:              next_state = ST_WB;
        endcase
      end
      ST_MEM:    if (dmem_ready) next_state = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
      ST_WB:     next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_RESET;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PLUS4;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_SEL_ALU;
    halt      = 1'b0;
    trap      = 1'b0;
    // ALU operand muxes stay stable from EXEC until the instruction retires
    if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
      alu_src_a = (cls_q == CLS_AUIPC) || (cls_q == CLS_JAL) || (cls_q == CLS_BRANCH);
      alu_src_b = !((cls_q == CLS_R) || (cls_q == CLS_BRANCH));
    end
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      ST_EXEC: begin
        if (cls_q == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
        end else if (cls_q == CLS_NOP) begin
          pc_we  = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_STORE);
        pc_we    = (cls_q == CLS_STORE) && dmem_ready;
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        case (cls_q)
          CLS_LOAD: wb_sel = WB_SEL_MEM;
          CLS_JAL:  begin wb_sel = WB_SEL_PC4; pc_sel = PC_SEL_IMM; end
          CLS_JALR: begin wb_sel = WB_SEL_PC4; pc_sel = PC_SEL_ALU; end
          default:  wb_sel = WB_SEL_ALU;
        endcase
      end
      ST_HALT: begin
        halt = 1'b1;
        trap = trap_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer against an instruction-level latency/strobe model.
module tb_cpu_sequencer;

  localparam int CNT_W = 32;
  localparam logic [6:0] B_R = 7'b0110011, B_I = 7'b0010011, B_LUI = 7'b0110111,
                         B_AUIPC = 7'b0010111, B_JAL = 7'b1101111, B_JALR = 7'b1100111,
                         B_LD = 7'b0000011, B_ST = 7'b0100011, B_BR = 7'b1100011,
                         B_SYS = 7'b1110011, B_FENCE = 7'b0001111;

  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_ready = 1'b0, dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic br_taken = 1'b0;
  logic ir_we, pc_we, alu_src_a, alu_src_b, reg_we, halt, trap;
  logic [1:0] pc_sel, wb_sel;
  logic [CNT_W-1:0] retire_cnt;

  int n_checks = 0, n_fail = 0;
  int model_cnt = 0;

  typedef struct {
    int lat; int irwe_cyc; int dreq_cyc; int dwe_bad; int regwe_cnt;
    logic [1:0] pc_sel; logic [1:0] wb_sel; logic src_a; logic src_b;
    logic [31:0] cnt_after; logic timeout;
  } obs_t;

  cpu_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .opcode(opcode), .funct3(funct3), .br_taken(br_taken), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_we(reg_we), .wb_sel(wb_sel), .halt(halt), .trap(trap), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Instruction-level reference model
  function automatic int m_lat(input logic [6:0] op, input int iw, input int dw);
    case (op)
      B_BR:                                  return 3 + iw;
      B_LD:                                  return 5 + iw + dw;
      B_ST:                                  return 4 + iw + dw;
      B_R, B_I, B_LUI, B_AUIPC, B_JAL, B_JALR: return 4 + iw;
      default:                               return 3 + iw;
    endcase
  endfunction
  function automatic logic [1:0] m_pcsel(input logic [6:0] op, input logic br);
    if (op == B_JAL) return 2'd1;
    if (op == B_JALR) return 2'd2;
    if (op == B_BR) return br ? 2'd1 : 2'd0;
    return 2'd0;
  endfunction
  function automatic logic [1:0] m_wbsel(input logic [6:0] op);
    if (op == B_LD) return 2'd1;
    if (op == B_JAL || op == B_JALR) return 2'd2;
    return 2'd0;
  endfunction
  function automatic int m_regwe(input logic [6:0] op);
    return (op == B_BR || op == B_ST || op == B_FENCE) ? 0 : 1;
  endfunction
  function automatic logic m_a(input logic [6:0] op);
    return (op == B_AUIPC || op == B_JAL || op == B_BR);
  endfunction
  function automatic logic m_b(input logic [6:0] op);
    return !(op == B_R || op == B_BR);
  endfunction

  // Drives one instruction from FETCH to its pc_we cycle; opcode is valid only in DECODE.
  task automatic run_instr(input logic [6:0] op, input logic br, input int iw, input int dw,
                           output obs_t o);
    int cyc = 0, fcnt = 0, mcnt = 0, guard = 0;
    bit started = 0, dec = 0, done = 0;
    o = '{default: 0};
    while (!done && guard < 200) begin
      guard++;
      if (imem_req) started = 1;
      if (started) cyc++;
      if (imem_req) begin imem_ready = (fcnt >= iw); fcnt++; end
      else imem_ready = 1'($urandom_range(0, 1));
      if (dmem_req) begin dmem_ready = (mcnt >= dw); mcnt++; end
      else dmem_ready = 1'($urandom_range(0, 1));
      opcode = dec ? op : 7'($urandom);
      funct3 = 3'($urandom);
      br_taken = br;
      dec = 0;
      #1;
      if (ir_we) begin dec = 1; o.irwe_cyc = cyc; end
      if (dmem_req) begin o.dreq_cyc++; if (dmem_we !== (op == B_ST)) o.dwe_bad++; end
      if (reg_we) o.regwe_cnt++;
      if (pc_we) begin
        done = 1; o.lat = cyc; o.pc_sel = pc_sel; o.wb_sel = wb_sel;
        o.src_a = alu_src_a; o.src_b = alu_src_b;
      end
      @(posedge clk); #1;
    end
    o.timeout = !done;
    o.cnt_after = retire_cnt;
  endtask

  // Fetches op and then watches the stopped core for a dozen cycles.
  task automatic run_to_halt(input logic [6:0] op, output int pcwe_n, output int ireq_after,
                             output int nohalt_after, output int dec_seen);
    bit dec = 0;
    int after = 0;
    pcwe_n = 0; ireq_after = 0; nohalt_after = 0; dec_seen = 0;
    for (int g = 0; g < 60 && after < 12; g++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      opcode = dec ? op : 7'($urandom);
      if (dec) dec_seen = 1;
      dec = 0;
      #1;
      if (pc_we) pcwe_n++;
      if (dec_seen && opcode != op) begin
        after++;
        if (imem_req) ireq_after++;
        if (!halt) nohalt_after++;
      end
      if (ir_we && !dec_seen) dec = 1;
      @(posedge clk); #1;
      if (dec_seen) opcode = 7'($urandom);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_a, alu_src_b, reg_we,
         wb_sel, halt, trap} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs: got strobes nonzero, want all 0");
    end
    n_checks++;
    if (retire_cnt !== 0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
    @(posedge clk); #1;
    rst = 1'b0; model_cnt = 0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_first_cycle: imem_req got %b want 0", imem_req); end
    @(posedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_entry: imem_req got %b want 1", imem_req); end
  endtask

  task automatic test_addi;
    obs_t o;
    run_instr(B_I, 1'b0, 0, 0, o);
    model_cnt++;
    n_checks++;
    if (o.irwe_cyc !== 1) begin n_fail++; $display("FAIL addi_ir_we_cycle: got %0d want 1", o.irwe_cyc); end
    n_checks++;
    if (o.lat !== 4) begin n_fail++; $display("FAIL addi_latency: got %0d want 4", o.lat); end
    n_checks++;
    if ({o.wb_sel, o.pc_sel, o.src_b} !== 5'b00001) begin
      n_fail++; $display("FAIL addi_muxes: wb_sel %0d pc_sel %0d src_b %b want 0 0 1", o.wb_sel, o.pc_sel, o.src_b);
    end
    n_checks++;
    if (o.regwe_cnt !== 1) begin n_fail++; $display("FAIL addi_reg_we: got %0d want 1", o.regwe_cnt); end
    n_checks++;
    if (o.cnt_after !== 32'(model_cnt)) begin n_fail++; $display("FAIL addi_retire: got %0d want %0d", o.cnt_after, model_cnt); end
  endtask

  task automatic test_load_wait;
    obs_t o;
    run_instr(B_LD, 1'b0, 0, 3, o);
    model_cnt++;
    n_checks++;
    if (o.dreq_cyc !== 4 || o.dwe_bad !== 0) begin
      n_fail++; $display("FAIL lw_dmem_req: cycles %0d bad_we %0d want 4 0", o.dreq_cyc, o.dwe_bad);
    end
    n_checks++;
    if (o.lat !== 8) begin n_fail++; $display("FAIL lw_latency: got %0d want 8", o.lat); end
    n_checks++;
    if (o.wb_sel !== 2'd1 || o.regwe_cnt !== 1) begin
      n_fail++; $display("FAIL lw_wb: wb_sel %0d reg_we %0d want 1 1", o.wb_sel, o.regwe_cnt);
    end
  endtask

  task automatic test_branch;
    obs_t o;
    for (int t = 1; t >= 0; t--) begin
      run_instr(B_BR, 1'(t), 0, 0, o);
      model_cnt++;
      n_checks++;
      if (o.lat !== 3 || o.pc_sel !== 2'(t) || o.regwe_cnt !== 0) begin
        n_fail++; $display("FAIL beq_taken%0d: lat %0d pc_sel %0d reg_we %0d want 3 %0d 0", t, o.lat, o.pc_sel, o.regwe_cnt, t);
      end
      n_checks++;
      if (o.cnt_after !== 32'(model_cnt)) begin n_fail++; $display("FAIL beq_retire: got %0d want %0d", o.cnt_after, model_cnt); end
    end
  endtask

  task automatic test_jalr;
    obs_t o;
    run_instr(B_JALR, 1'b0, 1, 0, o);
    model_cnt++;
    n_checks++;
    if (o.pc_sel !== 2'd2 || o.wb_sel !== 2'd2 || o.regwe_cnt !== 1 || o.lat !== 5) begin
      n_fail++; $display("FAIL jalr_wb: pc_sel %0d wb_sel %0d reg_we %0d lat %0d want 2 2 1 5", o.pc_sel, o.wb_sel, o.regwe_cnt, o.lat);
    end
  endtask

  task automatic test_random;
    logic [6:0] ops [9] = '{B_R, B_I, B_LUI, B_AUIPC, B_JAL, B_JALR, B_LD, B_ST, B_BR};
    obs_t o;
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op = ops[$urandom_range(0, 8)];
      logic br = 1'($urandom_range(0, 1));
      int iw = $urandom_range(0, 3), dw = $urandom_range(0, 3);
      int exp_dreq = (op == B_LD || op == B_ST) ? dw + 1 : 0;
      run_instr(op, br, iw, dw, o);
      model_cnt++;
      n_checks++;
      if (o.timeout || o.lat !== m_lat(op, iw, dw)) begin
        n_fail++; $display("FAIL rand%0d_latency op %b: got %0d want %0d", n, op, o.lat, m_lat(op, iw, dw));
      end
      n_checks++;
      if (o.irwe_cyc !== iw + 1) begin n_fail++; $display("FAIL rand%0d_ir_we: got %0d want %0d", n, o.irwe_cyc, iw + 1); end
      n_checks++;
      if (o.pc_sel !== m_pcsel(op, br) || o.wb_sel !== m_wbsel(op)) begin
        n_fail++; $display("FAIL rand%0d_sel op %b: pc_sel %0d wb_sel %0d want %0d %0d", n, op, o.pc_sel, o.wb_sel, m_pcsel(op, br), m_wbsel(op));
      end
      n_checks++;
      if (o.src_a !== m_a(op) || o.src_b !== m_b(op)) begin
        n_fail++; $display("FAIL rand%0d_alu_src op %b: a %b b %b want %b %b", n, op, o.src_a, o.src_b, m_a(op), m_b(op));
      end
      n_checks++;
      if (o.regwe_cnt !== m_regwe(op) || o.dreq_cyc !== exp_dreq || o.dwe_bad !== 0) begin
        n_fail++; $display("FAIL rand%0d_strobes op %b: reg_we %0d dreq %0d bad_we %0d want %0d %0d 0", n, op, o.regwe_cnt, o.dreq_cyc, o.dwe_bad, m_regwe(op), exp_dreq);
      end
      n_checks++;
      if (o.cnt_after !== 32'(model_cnt)) begin n_fail++; $display("FAIL rand%0d_retire: got %0d want %0d", n, o.cnt_after, model_cnt); end
    end
  endtask

  task automatic test_reset_mid_mem;
    obs_t o;
    bit dec = 0, found = 0;
    for (int g = 0; g < 20 && !found; g++) begin
      if (dmem_req) found = 1;
      else begin
        imem_ready = 1'b1; dmem_ready = 1'b0;
        opcode = dec ? B_LD : 7'($urandom);
        dec = 0;
        #1;
        if (ir_we) dec = 1;
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midmem_reach: dmem_req got 0 want 1 within 20 cycles"); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dmem_req !== 1'b0 || retire_cnt !== 0) begin
      n_fail++; $display("FAIL midmem_async: dmem_req %b retire_cnt %0d want 0 0", dmem_req, retire_cnt);
    end
    model_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midmem_release1: imem_req got %b want 0", imem_req); end
    @(posedge clk); #1;
    n_checks++;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL midmem_release2: imem_req got %b want 1", imem_req); end
    run_instr(B_AUIPC, 1'b0, 0, 0, o);
    model_cnt++;
    n_checks++;
    if (o.cnt_after !== 32'(model_cnt) || o.lat !== 4) begin
      n_fail++; $display("FAIL midmem_restart: cnt %0d lat %0d want %0d 4", o.cnt_after, o.lat, model_cnt);
    end
  endtask

  task automatic test_illegal;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    int pcwe_n, ireq_after, nohalt_after, dec_seen;
    run_to_halt(B_FENCE, pcwe_n, ireq_after, nohalt_after, dec_seen);
    n_checks++;
    if (!dec_seen || halt !== 1'b1 || trap !== 1'b1 || nohalt_after !== 0) begin
      n_fail++; $display("FAIL illegal_trap: halt %b trap %b nohalt %0d want 1 1 0", halt, trap, nohalt_after);
    end
    n_checks++;
    if (pcwe_n !== 0 || retire_cnt !== 32'(model_cnt)) begin
      n_fail++; $display("FAIL illegal_no_retire: pc_we %0d cnt %0d want 0 %0d", pcwe_n, retire_cnt, model_cnt);
    end
`else
    obs_t o;
    int iw = $urandom_range(0, 2);
    run_instr(B_FENCE, 1'b0, iw, 0, o);
    model_cnt++;
    n_checks++;
    if (o.lat !== m_lat(B_FENCE, iw, 0) || o.pc_sel !== 2'd0 || o.regwe_cnt !== 0) begin
      n_fail++; $display("FAIL illegal_nop: lat %0d pc_sel %0d reg_we %0d want %0d 0 0", o.lat, o.pc_sel, o.regwe_cnt, m_lat(B_FENCE, iw, 0));
    end
    n_checks++;
    if (o.cnt_after !== 32'(model_cnt) || trap !== 1'b0) begin
      n_fail++; $display("FAIL illegal_nop_retire: cnt %0d trap %b want %0d 0", o.cnt_after, trap, model_cnt);
    end
`endif
  endtask

  task automatic test_ecall;
    int pcwe_n, ireq_after, nohalt_after, dec_seen;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; model_cnt = 0;
    run_to_halt(B_SYS, pcwe_n, ireq_after, nohalt_after, dec_seen);
    n_checks++;
    if (!dec_seen || halt !== 1'b1 || nohalt_after !== 0 || trap !== 1'b0) begin
      n_fail++; $display("FAIL ecall_halt: halt %b nohalt %0d trap %b want 1 0 0", halt, nohalt_after, trap);
    end
    n_checks++;
    if (ireq_after !== 0 || pcwe_n !== 0 || retire_cnt !== 0) begin
      n_fail++; $display("FAIL ecall_quiet: imem_req %0d pc_we %0d cnt %0d want 0 0 0", ireq_after, pcwe_n, retire_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_load_wait;
    test_branch;
    test_jalr;
    test_random;
    test_reset_mid_mem;
    test_illegal;
    test_ecall;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
